oled_spi_sink: RTL and testbench
================================

// Module: oled_spi_sink
// PURPOSE
//  Display-side receiver for the write-only 4-wire SPI OLED link (csn/clk/mosi/dc) driven by the video
//  transmitter; models the SSD1331-style panel end. Oversamples the link in the system clock, assembles
//  bytes, decodes column/row window commands and turns data bytes into RRRGGGBB pixel writes with (x,y).
//  Used for on-chip loopback checking and as the bench model for the transmitter.
// PARAMETERS
//  WIDTH        96  panel columns; default column window 0..WIDTH-1
//  HEIGHT       64  panel rows; default row window 0..HEIGHT-1
//  SYNC_STAGES  2   synchroniser flops on every link input (>=2)
// PORTS
//  clk          in   1  system clock
//  rstn         in   1  asynchronous active-low reset
//  oled_csn     in   1  chip select, active low
//  oled_clk     in   1  SPI clock, idles low; mosi/dc sampled on rising edge
//  oled_mosi    in   1  serial data, MSB first
//  oled_dc      in   1  0 = command byte, 1 = pixel data byte
//  byte_valid   out  1  one-cycle pulse per complete byte
//  byte_data    out  8  received byte, valid with byte_valid
//  byte_is_cmd  out  1  dc of the byte (inverted), valid with byte_valid
//  pix_valid    out  1  one-cycle pulse per pixel write (data byte)
//  pix_x        out  8  column of pixel written
//  pix_y        out  6  row of pixel written
//  pix_color    out  8  pixel colour RRRGGGBB
//  frame_done   out  1  one-cycle pulse when pointer wraps from (col_end,row_end)
// BEHAVIOUR
//  Reset (async, rstn=0): all outputs 0; bit count 0; window col 0..WIDTH-1, row 0..HEIGHT-1; pointer (0,0); FSM IDLE.
//  Inputs: csn, clk, mosi, dc each pass SYNC_STAGES flops (equal depth, stay aligned). Rising edge = sync clk 0->1
//   vs one-cycle-delayed copy. Link requirement: oled_clk high and low phases each >= 2 clk periods.
//  Shift: on rising edge with sync csn=0, shift mosi into byte LSB, count++. At 8th bit: byte_valid=1 for exactly one
//   cycle, SYNC_STAGES+1 clk after the pin edge; byte_data/byte_is_cmd held until next byte; count -> 0.
//   dc is taken from the 8th-bit sample.
//  csn high: count cleared, partial byte discarded silently; window, pointer and FSM kept.
//  Command FSM (dc=0 bytes): IDLE -(0x15)-> COL_S -> COL_E -> IDLE; IDLE -(0x75)-> ROW_S -> ROW_E -> IDLE.
//   Other opcodes: reported on byte_* only, FSM stays IDLE. Args masked to 7 bits (col) / 6 bits (row) and
//   clamped to WIDTH-1 / HEIGHT-1; if end < start, end := start. On COL_E completion x := col_start;
//   on ROW_E completion y := row_start. Window/pointer change visible from the cycle after byte_valid.
//  Data byte (dc=1): pix_valid with byte_valid; pix_x/pix_y = current pointer, pix_color = byte. Then x++;
//   x==col_end -> x:=col_start, y++; additionally y==row_end -> y:=row_start, frame_done=1 (same cycle as
//   the pix_valid of the last pixel). Data byte while FSM not IDLE: FSM -> IDLE, pending args dropped
//   (window unchanged), byte still treated as pixel.
//  pix_x/pix_y/pix_color hold between pulses. No backpressure; consumers must accept each pulse.
// TESTING
//  1 After reset, send 0x15,0x00,0x5F,0x75,0x00,0x3F (dc=0) -> six byte_valid, byte_is_cmd=1, no pix_valid, window 0..95/0..63.
//  2 Send 96*64 data bytes 0x02 -> 6144 pix_valid, first (0,0), last (95,63) color 0x02, exactly one frame_done on last; next pixel (0,0).
//  3 Window 0x15,10,12,0x75,5,6 then 7 data bytes -> (10,5),(11,5),(12,5),(10,6),(11,6),(12,6) frame_done, (10,5).
//  4 csn rises after 5 bits, then full byte 0xA5 dc=1 -> no pulse for partial; one pix_valid color 0xA5.
//  5 0x15,0x7F,0x03 -> col_start clamped to 95, end forced 95; 0x15 then data byte 0x11 -> FSM IDLE, pixel written, window unchanged.
//  6 Assert rstn=0 mid-byte and mid-frame -> outputs 0 immediately, next full byte decoded cleanly, pointer (0,0).

Source files
------------

// File: rtl/oled_spi_sink_if.sv
// SPI OLED link pins plus the decoded byte/pixel results of the panel-side receiver.
// master drives the link and observes results; slave is the receiver.
interface oled_spi_sink_if;
   logic       oled_csn;
   logic       oled_clk;
   logic       oled_mosi;
   logic       oled_dc;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_is_cmd;
   logic       pix_valid;
   logic [7:0] pix_x;
   logic [5:0] pix_y;
   logic [7:0] pix_color;
   logic       frame_done;

   modport master (
      output oled_csn, oled_clk, oled_mosi, oled_dc,
      input  byte_valid, byte_data, byte_is_cmd,
      input  pix_valid, pix_x, pix_y, pix_color, frame_done
   );

   modport slave (
      input  oled_csn, oled_clk, oled_mosi, oled_dc,
      output byte_valid, byte_data, byte_is_cmd,
      output pix_valid, pix_x, pix_y, pix_color, frame_done
   );
endinterface

// File: rtl/oled_spi_sink.sv
// Oversampling SPI OLED receiver: bytes, column/row window commands, pixel writes with (x,y).
// byte/pixel pulses SYNC_STAGES+1 clk after the 8th SPI rising edge; no backpressure.
module oled_spi_sink #(
   parameter int WIDTH       = 96,
   parameter int HEIGHT      = 64,
   parameter int SYNC_STAGES = 2
) (
   input logic            clk,
   input logic            rstn,
   oled_spi_sink_if.slave link
);
   typedef enum logic [2:0] {IDLE, COL_S, COL_E, ROW_S, ROW_E} state_t;

   localparam logic [7:0] COL_MAX = 8'(WIDTH - 1);
   localparam logic [5:0] ROW_MAX = 6'(HEIGHT - 1);

   logic [SYNC_STAGES-1:0] csn_sync, clk_sync, mosi_sync, dc_sync;
   logic       clk_d;
   logic [2:0] bit_cnt;
   logic [6:0] shreg;
   state_t     state;
   logic [7:0] arg_start;
   logic [7:0] col_start, col_end, x;
   logic [5:0] row_start, row_end, y;

   logic       byte_valid_q, byte_is_cmd_q, pix_valid_q, frame_done_q;
   logic [7:0] byte_data_q, pix_x_q, pix_color_q;
   logic [5:0] pix_y_q;

   logic       csn_s, clk_s, mosi_s, dc_s, rise;
   logic [7:0] full_byte, col_arg;
   logic [5:0] row_arg;

   always_comb begin
      csn_s     = csn_sync[SYNC_STAGES-1];
      clk_s     = clk_sync[SYNC_STAGES-1];
      mosi_s    = mosi_sync[SYNC_STAGES-1];
      dc_s      = dc_sync[SYNC_STAGES-1];
      rise      = clk_s & ~clk_d;
      full_byte = {shreg, mosi_s};
      // >= instead of > keeps the clamp well-formed when the mask already fits the panel
      col_arg   = ({1'b0, full_byte[6:0]} >= COL_MAX) ? COL_MAX : {1'b0, full_byte[6:0]};
      row_arg   = (full_byte[5:0] >= ROW_MAX) ? ROW_MAX : full_byte[5:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         csn_sync      <= '1;
         clk_sync      <= '0;
         mosi_sync     <= '0;
         dc_sync       <= '0;
         clk_d         <= 1'b0;
         bit_cnt       <= '0;
         shreg         <= '0;
         state         <= IDLE;
         arg_start     <= '0;
         col_start     <= '0;
         col_end       <= COL_MAX;
         row_start     <= '0;
         row_end       <= ROW_MAX;
         x             <= '0;
         y             <= '0;
         byte_valid_q  <= 1'b0;
         byte_data_q   <= '0;
         byte_is_cmd_q <= 1'b0;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_color_q   <= '0;
         frame_done_q  <= 1'b0;
      end else begin
         csn_sync     <= {csn_sync[SYNC_STAGES-2:0], link.oled_csn};
         clk_sync     <= {clk_sync[SYNC_STAGES-2:0], link.oled_clk};
         mosi_sync    <= {mosi_sync[SYNC_STAGES-2:0], link.oled_mosi};
         dc_sync      <= {dc_sync[SYNC_STAGES-2:0], link.oled_dc};
         clk_d        <= clk_s;
         byte_valid_q <= 1'b0;
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;

         if (csn_s) begin
            bit_cnt <= '0;
         end else if (rise) begin
            shreg <= full_byte[6:0];
            if (bit_cnt != 3'd7) begin
               bit_cnt <= bit_cnt + 3'd1;
            end else begin
               bit_cnt       <= '0;
               byte_valid_q  <= 1'b1;
               byte_data_q   <= full_byte;
               byte_is_cmd_q <= ~dc_s;
               if (dc_s) begin
                  // a pixel aborts any half-received window command
                  state       <= IDLE;
                  pix_valid_q <= 1'b1;
                  pix_x_q     <= x;
                  pix_y_q     <= y;
                  pix_color_q <= full_byte;
                  if (x == col_end) begin
                     x <= col_start;
                     if (y == row_end) begin
                        y            <= row_start;
                        frame_done_q <= 1'b1;
                     end else begin
                        y <= y + 6'd1;
                     end
                  end else begin
                     x <= x + 8'd1;
                  end
               end else begin
                  case (state)
                     IDLE: begin
                        if (full_byte == 8'h15)      state <= COL_S;
                        else if (full_byte == 8'h75) state <= ROW_S;
                     end
                     COL_S: begin
                        arg_start <= col_arg;
                        state     <= COL_E;
                     end
                     COL_E: begin
                        col_start <= arg_start;
                        col_end   <= (col_arg < arg_start) ? arg_start : col_arg;
                        x         <= arg_start;
                        state     <= IDLE;
                     end
                     ROW_S: begin
                        arg_start <= {2'b00, row_arg};
                        state     <= ROW_E;
                     end
                     ROW_E: begin
                        row_start <= arg_start[5:0];
                        row_end   <= (row_arg < arg_start[5:0]) ? arg_start[5:0] : row_arg;
                        y         <= arg_start[5:0];
                        state     <= IDLE;
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         end
      end
   end

   assign link.byte_valid  = byte_valid_q;
   assign link.byte_data   = byte_data_q;
   assign link.byte_is_cmd = byte_is_cmd_q;
   assign link.pix_valid   = pix_valid_q;
   assign link.pix_x       = pix_x_q;
   assign link.pix_y       = pix_y_q;
   assign link.pix_color   = pix_color_q;
   assign link.frame_done  = frame_done_q;
endmodule

// File: tb/tb_oled_spi_sink.sv
// Bench for oled_spi_sink: directed sequences plus random traffic against a queue-based panel model.
module tb_oled_spi_sink;
   localparam int W    = 24;
   localparam int H    = 12;
   localparam int SYNC = 2;

   typedef struct {logic [7:0] d; logic cmd;} byte_t;
   typedef struct {int x; int y; logic [7:0] c; logic fd;} pix_t;

   logic clk;
   logic rstn;
   int   cyc;
   int   edge8_cyc;
   int   n_chk, n_pass;
   int   n_fd, exp_fd;

   byte_t exp_b[$];
   pix_t  exp_p[$];
   byte_t eb;
   pix_t  ep;
   logic [7:0] last_x, last_c;
   logic [5:0] last_y;

   // reference panel state
   int win_cs, win_ce, win_rs, win_re, px, py;
   int pend;      // 0 none, 1 awaiting col start, 2 col end, 3 row start, 4 row end
   int pend_arg;

   oled_spi_sink_if bus ();

   oled_spi_sink #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(SYNC)) dut (
      .clk  (clk),
      .rstn (rstn),
      .link (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, need completion)");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int clampi(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      win_cs = 0; win_ce = W - 1; win_rs = 0; win_re = H - 1;
      px = 0; py = 0; pend = 0; pend_arg = 0;
      exp_b.delete(); exp_p.delete();
      last_x = '0; last_y = '0; last_c = '0;
   endtask

   task automatic model_byte(input logic [7:0] b, input logic dc);
      int v;
      exp_b.push_back('{b, ~dc});
      if (dc) begin
         pix_t p;
         p.x = px; p.y = py; p.c = b;
         p.fd = (px == win_ce) && (py == win_re);
         if (p.fd) exp_fd++;
         exp_p.push_back(p);
         pend = 0;
         if (px == win_ce) begin
            px = win_cs;
            py = (py == win_re) ? win_rs : py + 1;
         end else begin
            px = px + 1;
         end
      end else begin
         case (pend)
            0: pend = (b == 8'h15) ? 1 : (b == 8'h75) ? 3 : 0;
            1: begin pend_arg = clampi(int'(b[6:0]), W - 1); pend = 2; end
            2: begin
               v = clampi(int'(b[6:0]), W - 1);
               win_cs = pend_arg; win_ce = (v < pend_arg) ? pend_arg : v;
               px = pend_arg; pend = 0;
            end
            3: begin pend_arg = clampi(int'(b[5:0]), H - 1); pend = 4; end
            default: begin
               v = clampi(int'(b[5:0]), H - 1);
               win_rs = pend_arg; win_re = (v < pend_arg) ? pend_arg : v;
               py = pend_arg; pend = 0;
            end
         endcase
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
      for (int i = 7; i >= 8 - nbits; i--) begin
         bus.oled_mosi = b[i];
         bus.oled_dc   = dc;
         tick($urandom_range(2, 3));
         if (i == 0) edge8_cyc = cyc;
         bus.oled_clk = 1'b1;
         tick($urandom_range(2, 3));
         bus.oled_clk = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic dc);
      model_byte(b, dc);
      send_bits(b, dc, 8);
   endtask

   task automatic abort_partial(input int nbits);
      send_bits(8'($urandom), 1'($urandom), nbits);
      bus.oled_csn = 1'b1;
      tick($urandom_range(3, 6));
      bus.oled_csn = 1'b0;
      tick(2);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_byte_valid"}, bus.byte_valid, 0);
      chk({tag, "_byte_data"}, bus.byte_data, 0);
      chk({tag, "_byte_is_cmd"}, bus.byte_is_cmd, 0);
      chk({tag, "_pix_valid"}, bus.pix_valid, 0);
      chk({tag, "_pix_x"}, bus.pix_x, 0);
      chk({tag, "_pix_y"}, bus.pix_y, 0);
      chk({tag, "_pix_color"}, bus.pix_color, 0);
      chk({tag, "_frame_done"}, bus.frame_done, 0);
   endtask

   task automatic release_reset();
      bus.oled_csn = 1'b1; bus.oled_clk = 1'b0; bus.oled_mosi = 1'b0; bus.oled_dc = 1'b0;
      tick(3);
      model_reset();
      rstn = 1'b1;
      tick(3);
      bus.oled_csn = 1'b0;
      tick(2);
   endtask

   // output monitor: every pulse is matched against the model queues
   always @(negedge clk) begin
      if (rstn) begin
         if (bus.byte_valid) begin
            if (exp_b.size() == 0) chk("byte_unexpected", 1, 0);
            else begin
               eb = exp_b.pop_front();
               chk("byte_data", bus.byte_data, eb.d);
               chk("byte_is_cmd", bus.byte_is_cmd, eb.cmd);
            end
            chk("byte_latency", cyc - edge8_cyc, SYNC + 1);
            if (!bus.pix_valid) begin
               chk("hold_pix_x", bus.pix_x, last_x);
               chk("hold_pix_y", bus.pix_y, last_y);
               chk("hold_pix_color", bus.pix_color, last_c);
            end
         end
         if (bus.pix_valid) begin
            if (!bus.byte_valid) chk("pix_without_byte", 1, 0);
            if (exp_p.size() == 0) chk("pix_unexpected", 1, 0);
            else begin
               ep = exp_p.pop_front();
               chk("pix_x", bus.pix_x, ep.x);
               chk("pix_y", bus.pix_y, ep.y);
               chk("pix_color", bus.pix_color, ep.c);
               chk("frame_done", bus.frame_done, ep.fd);
            end
            last_x = bus.pix_x; last_y = bus.pix_y; last_c = bus.pix_color;
         end else if (bus.frame_done) begin
            chk("frame_done_stray", 1, 0);
         end
         if (bus.frame_done) n_fd++;
      end
   end

   initial begin
      int fd0, r, k;
      n_chk = 0; n_pass = 0; n_fd = 0; exp_fd = 0; cyc = 0; edge8_cyc = 0;
      model_reset();
      rstn = 1'b0;
      bus.oled_csn = 1'b1; bus.oled_clk = 1'b0; bus.oled_mosi = 1'b0; bus.oled_dc = 1'b0;
      #1;
      check_outputs_zero("reset");
      release_reset();

      // full-window setup commands
      send_byte(8'h15, 0); send_byte(8'h00, 0); send_byte(8'(W - 1), 0);
      send_byte(8'h75, 0); send_byte(8'h00, 0); send_byte(8'(H - 1), 0);

      // one whole frame, then the pointer must wrap to (0,0)
      fd0 = exp_fd;
      for (int i = 0; i < W * H; i++) send_byte(8'h02, 1);
      send_byte(8'h02, 1);
      tick(6);
      chk("frame_count_full", n_fd - fd0, 1);

      // small window 10..12 x 5..6, seven pixels
      send_byte(8'h15, 0); send_byte(8'd10, 0); send_byte(8'd12, 0);
      send_byte(8'h75, 0); send_byte(8'd5, 0); send_byte(8'd6, 0);
      for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1);

      // partial byte dropped by csn, then a clean pixel
      abort_partial(5);
      send_byte(8'hA5, 1);

      // clamping and command aborted by a pixel
      send_byte(8'h15, 0); send_byte(8'h7F, 0); send_byte(8'h03, 0);
      send_byte(8'h33, 1);
      send_byte(8'h15, 0); send_byte(8'h11, 1);
      send_byte(8'h44, 1);

      // random traffic
      for (int it = 0; it < 150; it++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1: begin
               send_byte((r == 0) ? 8'h15 : 8'h75, 0);
               for (int a = 0; a < 2; a++)
                  send_byte(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, W + 2)), 0);
            end
            2: begin
               k = $urandom_range(0, 255);
               if (k == 8'h15 || k == 8'h75) k = 8'hAF;
               send_byte(8'(k), 0);
            end
            3: begin
               send_byte(($urandom_range(0, 1) != 0) ? 8'h15 : 8'h75, 0);
               if ($urandom_range(0, 1) != 0) send_byte(8'($urandom_range(0, 5)), 0);
               send_byte(8'($urandom), 1);
            end
            4: abort_partial($urandom_range(1, 7));
            default: begin
               k = $urandom_range(1, 6);
               for (int i = 0; i < k; i++) send_byte(8'($urandom), 1);
            end
         endcase
      end
      tick(8);
      chk("queue_bytes_left", exp_b.size(), 0);
      chk("queue_pix_left", exp_p.size(), 0);

      // asynchronous reset in the middle of a byte and of a frame
      send_byte(8'h5A, 1);
      send_bits(8'hC3, 1, 4);
      #2;
      rstn = 1'b0;
      #1;
      check_outputs_zero("midreset");
      release_reset();
      send_byte(8'h77, 1);
      send_byte(8'h78, 1);

      tick(10);
      chk("final_bytes_left", exp_b.size(), 0);
      chk("final_pix_left", exp_p.size(), 0);
      chk("frame_done_total", n_fd, exp_fd);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
